sram_port_arbiter: RTL and testbench

- Shares one SRAM-like slave port (req/addr_ok/data_ok) between two masters: instruction side (i_*) and data side (d_*, normally the store-buffer output).
- Sits between the CPU-side ports and the cache/AXI bridge.
- Supports multiple outstanding transactions with in-order responses.
- Keeps a FIFO of owner IDs so each slave data_ok is returned to the master that issued the request.

---
 rtl/sram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for a single SRAM-like slave port with in-order responses.
// Data-side (d_*) and instruction-side (i_*) requests share the slave; an owner FIFO routes each data_ok back.
module sram_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int PRIO_MODE       = 0
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               i_req,
    input  logic                               i_wr,
    input  logic [1:0]                         i_size,
    input  logic [31:0]                        i_addr,
    input  logic [31:0]                        i_wdata,
    input  logic [3:0]                         i_wstrb,
    output logic [31:0]                        i_rdata,
    output logic                               i_addr_ok,
    output logic                               i_data_ok,

    input  logic                               d_req,
    input  logic                               d_wr,
    input  logic [1:0]                         d_size,
    input  logic [31:0]                        d_addr,
    input  logic [31:0]                        d_wdata,
    input  logic [3:0]                         d_wstrb,
    output logic [31:0]                        d_rdata,
    output logic                               d_addr_ok,
    output logic                               d_data_ok,

    output logic                               s_req,
    output logic                               s_wr,
    output logic [1:0]                         s_size,
    output logic [31:0]                        s_addr,
    output logic [31:0]                        s_wdata,
    output logic [3:0]                         s_wstrb,
    input  logic [31:0]                        s_rdata,
    input  logic                               s_addr_ok,
    input  logic                               s_data_ok,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               proto_err
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    // Owner encoding: 1 = data master, 0 = instruction master.
    logic          r_owner [MAX_OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_lock_valid;
    logic          r_lock_owner;
    logic          r_last_grant;
    logic          r_proto_err;
    logic          r_rst_q;

    logic w_grant;
    logic w_greq;
    logic w_full;
    logic w_empty;
    logic w_block;
    logic w_hs;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_cnt == CW'(MAX_OUTSTANDING));
    assign w_empty = (r_cnt == '0);
    // Handshakes stay quiet during reset and for one cycle after it.
    assign w_block = rst | r_rst_q;

    always_comb begin
        w_grant = 1'b1;
        if (r_lock_valid) begin
            w_grant = r_lock_owner;
        end else if (d_req && !i_req) begin
            w_grant = 1'b1;
        end else if (i_req && !d_req) begin
            w_grant = 1'b0;
        end else if (i_req && d_req) begin
            w_grant = (PRIO_MODE == 0) ? 1'b1 : ~r_last_grant;
        end
    end

    assign w_greq = w_grant ? d_req : i_req;

    assign s_req   = w_greq && !w_full && !w_block;
    assign s_wr    = w_grant ? d_wr    : i_wr;
    assign s_size  = w_grant ? d_size  : i_size;
    assign s_addr  = w_grant ? d_addr  : i_addr;
    assign s_wdata = w_grant ? d_wdata : i_wdata;
    assign s_wstrb = w_grant ? d_wstrb : i_wstrb;

    assign w_hs      = s_req && s_addr_ok;
    assign d_addr_ok = w_hs &&  w_grant;
    assign i_addr_ok = w_hs && !w_grant;

    assign w_head    = r_owner[r_rptr];
    assign w_pop     = s_data_ok && !w_empty && !w_block;
    assign d_data_ok = w_pop &&  w_head;
    assign i_data_ok = w_pop && !w_head;
    assign i_rdata   = s_rdata;
    assign d_rdata   = s_rdata;

    assign outstanding = r_cnt;
    assign proto_err   = r_proto_err;

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_owner[r_wptr] <= w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_cnt        <= '0;
            r_lock_valid <= 1'b0;
            r_lock_owner <= 1'b0;
            r_last_grant <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_wptr       <= r_wptr + PW'(1);
                r_last_grant <= w_grant;
                r_lock_valid <= 1'b0;
            end else if (s_req) begin
                r_lock_valid <= 1'b1;
                r_lock_owner <= w_grant;
            end else if (r_lock_valid && !w_greq) begin
                r_lock_valid <= 1'b0;
            end

            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end

            case ({w_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase

            if (s_data_ok && w_empty) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one fixed-priority and one round-robin instance share stimulus.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        i_req = 1'b0, i_wr = 1'b0;
    logic [1:0]  i_size = 2'd2;
    logic [31:0] i_addr = '0, i_wdata = '0;
    logic [3:0]  i_wstrb = 4'hf;
    logic        d_req = 1'b0, d_wr = 1'b1;
    logic [1:0]  d_size = 2'd2;
    logic [31:0] d_addr = '0, d_wdata = 32'hCAFE0000;
    logic [3:0]  d_wstrb = 4'hf;
    logic [31:0] s_rdata = '0;
    logic        s_addr_ok = 1'b0, s_data_ok = 1'b0;

    logic [31:0] a_i_rdata, a_d_rdata, a_s_addr, a_s_wdata;
    logic        a_i_addr_ok, a_i_data_ok, a_d_addr_ok, a_d_data_ok, a_s_req, a_s_wr, a_proto_err;
    logic [1:0]  a_s_size;
    logic [3:0]  a_s_wstrb;
    logic [2:0]  a_outstanding;

    logic [31:0] b_i_rdata, b_d_rdata, b_s_addr, b_s_wdata;
    logic        b_i_addr_ok, b_i_data_ok, b_d_addr_ok, b_d_data_ok, b_s_req, b_s_wr, b_proto_err;
    logic [1:0]  b_s_size;
    logic [3:0]  b_s_wstrb;
    logic [2:0]  b_outstanding;

    int n_chk  = 0;
    int n_fail = 0;

    sram_port_arbiter #(.MAX_OUTSTANDING(4), .PRIO_MODE(0)) dut_a (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .i_rdata(a_i_rdata), .i_addr_ok(a_i_addr_ok), .i_data_ok(a_i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(a_d_rdata), .d_addr_ok(a_d_addr_ok), .d_data_ok(a_d_data_ok),
        .s_req(a_s_req), .s_wr(a_s_wr), .s_size(a_s_size), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
        .s_wstrb(a_s_wstrb), .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .outstanding(a_outstanding), .proto_err(a_proto_err)
    );

    sram_port_arbiter #(.MAX_OUTSTANDING(4), .PRIO_MODE(1)) dut_b (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .i_rdata(b_i_rdata), .i_addr_ok(b_i_addr_ok), .i_data_ok(b_i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(b_d_rdata), .d_addr_ok(b_d_addr_ok), .d_data_ok(b_d_data_ok),
        .s_req(b_s_req), .s_wr(b_s_wr), .s_size(b_s_size), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
        .s_wstrb(b_s_wstrb), .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .outstanding(b_outstanding), .proto_err(b_proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset cycle and the blocked cycle after it
        i_req = 1'b1; s_addr_ok = 1'b1;
        cyc(); #1;
        chk("rst_sreq", a_s_req, 0);
        chk("rst_iaok", a_i_addr_ok, 0);
        cyc(); rst = 1'b0; #1;
        chk("post_rst_sreq", a_s_req, 0);
        chk("post_rst_iaok", a_i_addr_ok, 0);
        chk("rst_outst", a_outstanding, 0);
        chk("rst_perr", a_proto_err, 0);
        i_req = 1'b0; s_addr_ok = 1'b0;
        cyc();

        // Solo instruction read
        i_req = 1'b1; i_addr = 32'hBFC00000; s_addr_ok = 1'b1; #1;
        chk("t1_sreq", a_s_req, 1);
        chk("t1_saddr", a_s_addr, 32'hBFC00000);
        chk("t1_iaok", a_i_addr_ok, 1);
        chk("t1_daok", a_d_addr_ok, 0);
        cyc(); i_req = 1'b0; s_addr_ok = 1'b0; #1;
        chk("t1_outst1", a_outstanding, 1);
        cyc(); #1;
        chk("t1_ddok_idle", a_d_data_ok, 0);
        chk("t1_idok_idle", a_i_data_ok, 0);
        cyc(); s_data_ok = 1'b1; s_rdata = 32'h12345678; #1;
        chk("t1_idok", a_i_data_ok, 1);
        chk("t1_irdata", a_i_rdata, 32'h12345678);
        chk("t1_ddok", a_d_data_ok, 0);
        cyc(); s_data_ok = 1'b0; #1;
        chk("t1_outst0", a_outstanding, 0);

        // Contention: fixed priority on dut_a, round-robin on dut_b (last grant was I)
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h1000; d_addr = 32'h2000; s_addr_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_a_saddr", a_s_addr, 32'h2000);
            chk("t2_a_daok", a_d_addr_ok, 1);
            chk("t2_a_iaok", a_i_addr_ok, 0);
            chk("t2_b_saddr", b_s_addr, (k == 1) ? 32'h1000 : 32'h2000);
            chk("t2_b_iaok", b_i_addr_ok, (k == 1) ? 1 : 0);
            cyc();
        end
        i_req = 1'b0; d_req = 1'b0; s_addr_ok = 1'b0; #1;
        chk("t2_a_outst", a_outstanding, 3);
        s_data_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_rdata = k; #1;
            chk("t2_a_ddok", a_d_data_ok, 1);
            chk("t2_b_idok", b_i_data_ok, (k == 1) ? 1 : 0);
            chk("t2_b_ddok", b_d_data_ok, (k == 1) ? 0 : 1);
            cyc();
        end
        s_data_ok = 1'b0; #1;
        chk("t2_b_outst", b_outstanding, 0);

        // Lock: slave stalls the data request; round-robin must not switch to I
        d_req = 1'b1; d_addr = 32'h3000; s_addr_ok = 1'b0; #1;
        chk("t3_a_saddr", a_s_addr, 32'h3000);
        chk("t3_a_daok", a_d_addr_ok, 0);
        cyc();
        i_req = 1'b1; i_addr = 32'h1000;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t3_b_saddr_stall", b_s_addr, 32'h3000);
            chk("t3_b_iaok_stall", b_i_addr_ok, 0);
            cyc();
        end
        s_addr_ok = 1'b1; #1;
        chk("t3_b_saddr_acc", b_s_addr, 32'h3000);
        chk("t3_b_daok", b_d_addr_ok, 1);
        cyc();
        d_req = 1'b0; #1;
        chk("t3_b_saddr_i", b_s_addr, 32'h1000);
        chk("t3_b_iaok", b_i_addr_ok, 1);
        cyc();

        // Lock onto I, then reset mid-flight with two outstanding
        i_req = 1'b1; d_req = 1'b0; s_addr_ok = 1'b0; #1;
        chk("t6_b_outst2", b_outstanding, 2);
        cyc();
        rst = 1'b1; i_req = 1'b0;
        cyc();
        rst = 1'b0; #1;
        chk("t6_a_outst0", a_outstanding, 0);
        chk("t6_b_outst0", b_outstanding, 0);
        chk("t6_b_perr0", b_proto_err, 0);
        cyc();
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h1000; d_addr = 32'h2000; #1;
        chk("t6_b_nolock", b_s_addr, 32'h2000);
        chk("t6_a_saddr", a_s_addr, 32'h2000);
        cyc();
        i_req = 1'b0; d_req = 1'b0;
        cyc();
        s_data_ok = 1'b1; #1;
        chk("t6_empty_idok", a_i_data_ok, 0);
        chk("t6_empty_ddok", a_d_data_ok, 0);
        cyc();
        s_data_ok = 1'b0; #1;
        chk("t6_perr", a_proto_err, 1);
        cyc(); #1;
        chk("t6_perr_sticky", a_proto_err, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();

        // Full FIFO holds s_req low even when a pop lands in the same cycle
        i_req = 1'b1; i_addr = 32'h4000; s_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_iaok", a_i_addr_ok, 1);
            cyc();
        end
        #1;
        chk("t4_outst4", a_outstanding, 4);
        chk("t4_sreq_full", a_s_req, 0);
        chk("t4_iaok_full", a_i_addr_ok, 0);
        s_data_ok = 1'b1; #1;
        chk("t4_sreq_fullpop", a_s_req, 0);
        chk("t4_idok", a_i_data_ok, 1);
        cyc();
        s_data_ok = 1'b0; #1;
        chk("t4_outst3", a_outstanding, 3);
        chk("t4_sreq_again", a_s_req, 1);
        chk("t4_iaok_again", a_i_addr_ok, 1);
        cyc();
        i_req = 1'b0; s_addr_ok = 1'b0; #1;
        chk("t4_outst4b", a_outstanding, 4);
        s_data_ok = 1'b1;
        repeat (4) cyc();
        s_data_ok = 1'b0; #1;
        chk("t4_drained", a_outstanding, 0);

        // Ordering I,D,D,I with overlapping accept and response
        i_req = 1'b1; s_addr_ok = 1'b1; #1;
        chk("t5_c0_iaok", a_i_addr_ok, 1);
        cyc();
        i_req = 1'b0; d_req = 1'b1; s_data_ok = 1'b1; s_rdata = 32'd1; #1;
        chk("t5_c1_idok", a_i_data_ok, 1);
        chk("t5_c1_irdata", a_i_rdata, 1);
        chk("t5_c1_daok", a_d_addr_ok, 1);
        chk("t5_c1_outst", a_outstanding, 1);
        cyc();
        s_rdata = 32'd2; #1;
        chk("t5_c2_ddok", a_d_data_ok, 1);
        chk("t5_c2_idok", a_i_data_ok, 0);
        chk("t5_c2_drdata", a_d_rdata, 2);
        chk("t5_c2_outst", a_outstanding, 1);
        cyc();
        d_req = 1'b0; i_req = 1'b1; s_rdata = 32'd3; #1;
        chk("t5_c3_ddok", a_d_data_ok, 1);
        chk("t5_c3_iaok", a_i_addr_ok, 1);
        chk("t5_c3_outst", a_outstanding, 1);
        cyc();
        i_req = 1'b0; s_addr_ok = 1'b0; s_rdata = 32'd4; #1;
        chk("t5_c4_idok", a_i_data_ok, 1);
        chk("t5_c4_ddok", a_d_data_ok, 0);
        chk("t5_c4_irdata", a_i_rdata, 4);
        chk("t5_c4_outst", a_outstanding, 1);
        cyc();
        s_data_ok = 1'b0; #1;
        chk("t5_outst0", a_outstanding, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
